// File: rtl/simd_result_unloader.sv
`default_nettype none
// ============================================================================
//  Module      : simd_result_unloader
//  Description : Collects paired ALU results on each completion edge into a
//                result buffer, then streams the buffer to the host over a
//                valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module simd_result_unloader #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_start,
    input  logic [5:0]  wb_length,
    input  logic        procc_done,
    input  logic [31:0] in_procc0,
    input  logic [31:0] in_extra_procc0,
    input  logic [31:0] in_procc1,
    input  logic [31:0] in_extra_procc1,
    input  logic        host_ready,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic [63:0] out_extra,
    output logic [5:0]  out_index,
    output logic        wb_busy,
    output logic        wb_done,
    output logic        wb_overflow
);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_COLLECT = 2'd1;
    localparam logic [1:0] c_S_DRAIN   = 2'd2;
    localparam logic [1:0] c_S_DONE    = 2'd3;

    logic [1:0]   r_state;
    logic [5:0]   r_len;
    logic [5:0]   r_wr_ptr;
    logic [5:0]   r_rd_ptr;
    logic         r_prev;
    logic         r_overflow;
    logic [127:0] r_buf [DEPTH];

    logic         w_cap;
    logic         w_in_drain;
    logic         w_xfer;
    logic [5:0]   w_wr_next;
    logic [5:0]   w_last_rd;
    logic [127:0] w_word;

    assign w_cap      = procc_done & ~r_prev;
    assign w_in_drain = (r_state == c_S_DRAIN);
    assign w_xfer     = w_in_drain & host_ready;
    assign w_wr_next  = r_wr_ptr + 6'd1;
    assign w_last_rd  = r_len - 6'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_S_IDLE;
            r_len      <= 6'd0;
            r_wr_ptr   <= 6'd0;
            r_rd_ptr   <= 6'd0;
            r_prev     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_prev <= procc_done;
            case (r_state)
                c_S_IDLE: begin
                    if (wb_start) begin
                        r_len      <= wb_length;
                        r_wr_ptr   <= 6'd0;
                        r_rd_ptr   <= 6'd0;
                        r_overflow <= 1'b0;
                        r_state    <= (wb_length == 6'd0) ? c_S_DONE : c_S_COLLECT;
                    end
                end
                c_S_COLLECT: begin
                    if (w_cap) begin
                        r_wr_ptr <= w_wr_next;
                        if (w_wr_next == r_len) begin
                            r_state <= c_S_DRAIN;
                        end
                    end
                end
                c_S_DRAIN: begin
                    // Completion edges after collection are dropped but flagged
                    if (w_cap) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_xfer) begin
                        r_rd_ptr <= r_rd_ptr + 6'd1;
                        if (r_rd_ptr == w_last_rd) begin
                            r_state <= c_S_DONE;
                        end
                    end
                end
                default: begin
                    if (w_cap) begin
                        r_overflow <= 1'b1;
                    end
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Buffer storage carries no reset; stale contents are never presented
    always_ff @(posedge clk) begin
        if (!reset && (r_state == c_S_COLLECT) && w_cap) begin
            r_buf[r_wr_ptr] <= {in_procc0, in_procc1, in_extra_procc0, in_extra_procc1};
        end
    end

    assign w_word      = r_buf[r_rd_ptr];
    assign out_valid   = w_in_drain;
    assign out_data    = w_in_drain ? w_word[127:64] : 64'd0;
    assign out_extra   = w_in_drain ? w_word[63:0]   : 64'd0;
    assign out_index   = w_in_drain ? r_rd_ptr       : 6'd0;
    assign wb_busy     = (r_state != c_S_IDLE);
    assign wb_done     = (r_state == c_S_DONE);
    assign wb_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_simd_result_unloader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simd_result_unloader
//  Description : Directed self-checking bench for simd_result_unloader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_result_unloader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_start = 1'b0;
    logic [5:0]  wb_length = 6'd0;
    logic        procc_done = 1'b0;
    logic [31:0] in_procc0 = 32'd0;
    logic [31:0] in_extra_procc0 = 32'd0;
    logic [31:0] in_procc1 = 32'd0;
    logic [31:0] in_extra_procc1 = 32'd0;
    logic        host_ready = 1'b0;
    logic        out_valid;
    logic [63:0] out_data;
    logic [63:0] out_extra;
    logic [5:0]  out_index;
    logic        wb_busy;
    logic        wb_done;
    logic        wb_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    simd_result_unloader #(.DEPTH(64)) dut (
        .clk             (clk),
        .reset           (reset),
        .wb_start        (wb_start),
        .wb_length       (wb_length),
        .procc_done      (procc_done),
        .in_procc0       (in_procc0),
        .in_extra_procc0 (in_extra_procc0),
        .in_procc1       (in_procc1),
        .in_extra_procc1 (in_extra_procc1),
        .host_ready      (host_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_extra       (out_extra),
        .out_index       (out_index),
        .wb_busy         (wb_busy),
        .wb_done         (wb_done),
        .wb_overflow     (wb_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_data(input int e);
        return {32'h11 + 32'(e), 32'h22 + 32'(e)};
    endfunction

    function automatic logic [63:0] exp_extra(input int e);
        return {32'hA + 32'(e), 32'hB + 32'(e)};
    endfunction

    // Inputs change on the falling edge; outputs are sampled there too
    task automatic start_job(input logic [5:0] len);
        wb_start  = 1'b1;
        wb_length = len;
        @(negedge clk);
        wb_start  = 1'b0;
    endtask

    task automatic send_elem(input int e, input int hold);
        in_procc0       = 32'h11 + 32'(e);
        in_procc1       = 32'h22 + 32'(e);
        in_extra_procc0 = 32'hA + 32'(e);
        in_extra_procc1 = 32'hB + 32'(e);
        procc_done      = 1'b1;
        repeat (hold) @(negedge clk);
        procc_done      = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input int len, input bit toggle);
        int idx = 0;
        int cyc = 0;
        int budget = 4 * len + 10;
        bit hr;
        while (idx < len && cyc < budget) begin
            check_eq("drain_valid", 128'(out_valid), 128'(1));
            check_eq("drain_index", 128'(out_index), 128'(idx));
            check_eq("drain_data",  128'(out_data),  128'(exp_data(idx)));
            check_eq("drain_extra", 128'(out_extra), 128'(exp_extra(idx)));
            hr = toggle ? cyc[0] : 1'b1;
            host_ready = hr;
            @(negedge clk);
            if (hr) idx++;
            cyc++;
        end
        host_ready = 1'b0;
        check_eq("drain_count",  128'(idx), 128'(len));
        check_eq("drain_cycles", 128'(cyc), 128'(toggle ? 2 * len : len));
        check_eq("done_pulse",   128'(wb_done), 128'(1));
        check_eq("done_busy",    128'(wb_busy), 128'(1));
        check_eq("done_novalid", 128'(out_valid), 128'(0));
        @(negedge clk);
        check_eq("idle_busy", 128'(wb_busy), 128'(0));
        check_eq("idle_done", 128'(wb_done), 128'(0));
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_valid",    128'(out_valid), 128'(0));
        check_eq("rst_data",     128'(out_data), 128'(0));
        check_eq("rst_extra",    128'(out_extra), 128'(0));
        check_eq("rst_index",    128'(out_index), 128'(0));
        check_eq("rst_busy",     128'(wb_busy), 128'(0));
        check_eq("rst_done",     128'(wb_done), 128'(0));
        check_eq("rst_overflow", 128'(wb_overflow), 128'(0));

        // Basic three-element job with host always ready
        start_job(6'd3);
        check_eq("basic_busy",    128'(wb_busy), 128'(1));
        check_eq("basic_novalid", 128'(out_valid), 128'(0));
        for (int e = 0; e < 3; e++) send_elem(e, 1);
        drain(3, 1'b0);
        check_eq("basic_overflow", 128'(wb_overflow), 128'(0));

        // Held completion level captures once; host toggles ready
        start_job(6'd2);
        for (int e = 0; e < 2; e++) send_elem(e, 4);
        drain(2, 1'b1);
        check_eq("level_overflow", 128'(wb_overflow), 128'(0));

        // Extra completion edge after collection sets sticky overflow
        start_job(6'd1);
        send_elem(0, 1);
        send_elem(9, 1);
        check_eq("ovf_set", 128'(wb_overflow), 128'(1));
        drain(1, 1'b0);
        check_eq("ovf_sticky", 128'(wb_overflow), 128'(1));

        // Zero length: done next cycle, never valid; also clears overflow
        start_job(6'd0);
        check_eq("len0_done",     128'(wb_done), 128'(1));
        check_eq("len0_busy",     128'(wb_busy), 128'(1));
        check_eq("len0_novalid",  128'(out_valid), 128'(0));
        check_eq("len0_ovf_clr",  128'(wb_overflow), 128'(0));
        @(negedge clk);
        check_eq("len0_idle",     128'(wb_busy), 128'(0));
        check_eq("len0_done_end", 128'(wb_done), 128'(0));
        check_eq("len0_novalid2", 128'(out_valid), 128'(0));

        // wb_start during collection is ignored
        start_job(6'd3);
        send_elem(0, 1);
        wb_start  = 1'b1;
        wb_length = 6'd1;
        @(negedge clk);
        wb_start  = 1'b0;
        check_eq("ign_busy",    128'(wb_busy), 128'(1));
        check_eq("ign_novalid", 128'(out_valid), 128'(0));
        send_elem(1, 1);
        send_elem(2, 1);
        drain(3, 1'b0);

        // Maximum length job
        start_job(6'd63);
        for (int e = 0; e < 63; e++) send_elem(e, 1);
        drain(63, 1'b0);

        // Reset in the middle of draining
        start_job(6'd2);
        send_elem(0, 1);
        send_elem(1, 1);
        send_elem(7, 1);
        check_eq("mid_valid",    128'(out_valid), 128'(1));
        check_eq("mid_overflow", 128'(wb_overflow), 128'(1));
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("mrst_valid",    128'(out_valid), 128'(0));
        check_eq("mrst_busy",     128'(wb_busy), 128'(0));
        check_eq("mrst_overflow", 128'(wb_overflow), 128'(0));
        check_eq("mrst_data",     128'(out_data), 128'(0));
        check_eq("mrst_index",    128'(out_index), 128'(0));
        @(negedge clk);
        check_eq("mrst_stay_idle", 128'(wb_busy), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
